// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: opcodes, bubble instruction and FSM state encodings.
package fetch_stage_pkg;

  localparam int unsigned FETCH_W = 16;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;

  localparam logic [FETCH_W-1:0] NOP_INSTR = {OP_NOP, 11'b0};

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between the fetch stage and imem.
interface fetch_stage_if #(
  parameter int unsigned W = 16
);
  logic [W-1:0] imem_addr;
  logic         imem_req;
  logic [W-1:0] imem_rdata;
  logic         imem_done;

  modport master (output imem_addr, imem_req, input imem_rdata, imem_done);
  modport slave  (input imem_addr, imem_req, output imem_rdata, imem_done);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an (instr, pc2) pair; clear and drain take priority over load.
module fetch_skid_buf #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  logic [W-1:0] load_instr,
  input  logic [W-1:0] load_pc2,
  output logic         valid,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc2
);

  logic         valid_q, valid_d;
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pc2_q, pc2_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc2_d   = pc2_q;
    if (clear || drain) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc2_d   = load_pc2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc2   = pc2_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: PC, imem handshake, stall, redirect and halt.
// Define FETCH_SKID_EN to keep a word returned during a decode stall in a one-entry skid buffer.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned         INSTR_W   = 16,
  parameter logic [INSTR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 stall_id,
  input  logic                 redirect,
  input  logic [INSTR_W-1:0]   redirect_pc,
  input  logic                 halt_id,
  output logic [INSTR_W-1:0]   if_id_instr,
  output logic [INSTR_W-1:0]   if_id_pc2,
  output logic                 if_id_valid,
  output logic                 fetch_busy
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc2_q, pc2_d;
  logic               valid_q, valid_d;
  logic               squash_q, squash_d;
  logic [INSTR_W-1:0] stale_addr_q, stale_addr_d;

  logic               imem_req_c;
  logic [INSTR_W-1:0] imem_addr_c;
  logic [INSTR_W-1:0] pc_plus2;
  logic               take;

`ifdef FETCH_SKID_EN
  logic               skid_load, skid_drain, skid_clear, skid_valid;
  logic [INSTR_W-1:0] skid_instr, skid_pc2;

  fetch_skid_buf #(.W(INSTR_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (skid_clear),
    .load_instr (imem.imem_rdata),
    .load_pc2   (pc_plus2),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc2        (skid_pc2)
  );
`endif

  // A squashed request keeps its original address until memory completes it.
  assign imem_addr_c = squash_q ? stale_addr_q : pc_q;
  assign pc_plus2    = pc_q + INSTR_W'(2);
  assign take        = imem_req_c && imem.imem_done;

  always_comb begin
    imem_req_c = 1'b0;
    if (!rst && state_q != HALTED) begin
      imem_req_c = 1'b1;
`ifdef FETCH_SKID_EN
      if (skid_valid) imem_req_c = 1'b0;
`else
      if (state_q == FETCH && stall_id) imem_req_c = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc2_d        = pc2_q;
    valid_d      = valid_q;
    squash_d     = squash_q;
    stale_addr_d = stale_addr_q;
`ifdef FETCH_SKID_EN
    skid_load    = 1'b0;
    skid_drain   = 1'b0;
    skid_clear   = 1'b0;
`endif

    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (redirect) begin
      // Redirect beats halt so a wrong-path HALT cannot freeze the core.
      pc_d    = redirect_pc;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
`ifdef FETCH_SKID_EN
      skid_clear = 1'b1;
`endif
      if (imem_req_c && !imem.imem_done) begin
        state_d      = WAIT;
        squash_d     = 1'b1;
        stale_addr_d = imem_addr_c;
      end else begin
        state_d  = FETCH;
        squash_d = 1'b0;
      end
    end else if (halt_id) begin
      state_d  = HALTED;
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      squash_d = 1'b0;
`ifdef FETCH_SKID_EN
      skid_clear = 1'b1;
`endif
    end else if (squash_q) begin
      if (imem.imem_done) begin
        squash_d = 1'b0;
        state_d  = FETCH;
      end
    end else begin
      state_d = (imem_req_c && !imem.imem_done) ? WAIT : FETCH;
`ifdef FETCH_SKID_EN
      if (stall_id) begin
        if (take) begin
          skid_load = 1'b1;
          pc_d      = pc_plus2;
        end
      end else if (skid_valid) begin
        instr_d    = skid_instr;
        pc2_d      = skid_pc2;
        valid_d    = 1'b1;
        skid_drain = 1'b1;
      end else if (take) begin
        instr_d = imem.imem_rdata;
        pc2_d   = pc_plus2;
        valid_d = 1'b1;
        pc_d    = pc_plus2;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
`else
      // A word returned during a stall is dropped; pc is unchanged so it is refetched.
      if (!stall_id) begin
        if (take) begin
          instr_d = imem.imem_rdata;
          pc2_d   = pc_plus2;
          valid_d = 1'b1;
          pc_d    = pc_plus2;
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc2_q        <= '0;
      valid_q      <= 1'b0;
      squash_q     <= 1'b0;
      stale_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc2_q        <= pc2_d;
      valid_q      <= valid_d;
      squash_q     <= squash_d;
      stale_addr_q <= stale_addr_d;
    end
  end

  assign imem.imem_req  = imem_req_c;
  assign imem.imem_addr = imem_addr_c;
  assign if_id_instr    = instr_q;
  assign if_id_pc2      = pc2_q;
  assign if_id_valid    = valid_q;
  assign fetch_busy     = (state_q == WAIT);

endmodule
